// File: rtl/ysyx_22041207_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22041207_pipe_pkg
// Brief    : Shared constants for the NPC inter-stage pipeline registers.
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_22041207_pipe_pkg;

    // Skid-mode FSM encoding; the encoding doubles as the occupancy count.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    // Decoded control bundle carried from ID onwards.
    localparam int CTRL_REG_WEN_BIT = 0;
    localparam int CTRL_MEM_REN_BIT = 1;
    localparam int CTRL_MEM_WEN_BIT = 2;
    localparam int CTRL_ALU_OP_LSB  = 3;
    localparam int CTRL_ALU_OP_W    = 4;
    localparam int CTRL_W           = CTRL_ALU_OP_LSB + CTRL_ALU_OP_W;

    // Stage payload widths (pc, instruction, operands, results, rd index).
    localparam int IF_ID_W  = 64 + 32;
    localparam int ID_EX_W  = 64 + 32 + 64 + 64 + 64 + 5 + CTRL_W;
    localparam int EX_MEM_W = 64 + 64 + 64 + 5 + CTRL_W;
    localparam int MEM_WB_W = 64 + 64 + 5 + 1;

endpackage
`default_nettype wire

// File: rtl/ysyx_22041207_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22041207_pipe_stage
// Brief    : Parametrised valid/ready pipeline register with flush and skid.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22041207_pipe_stage
    import ysyx_22041207_pipe_pkg::*;
#(
    parameter int              DATA_W         = 64,
    parameter int              SKID           = 1,
    parameter int              CLEAR_ON_FLUSH = 1,
    parameter logic [DATA_W-1:0] RESET_DATA   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic w_accept;
    logic w_send;

    assign w_accept = in_valid & in_ready;
    assign w_send   = out_valid & out_ready;

    generate
        if (SKID == 0) begin : g_single
            logic              r_valid;
            logic [DATA_W-1:0] r_main;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid <= 1'b0;
                    r_main  <= RESET_DATA;
                end else if (flush) begin
                    r_valid <= 1'b0;
                    if (CLEAR_ON_FLUSH != 0) r_main <= '0;
                end else if (w_accept) begin
                    r_valid <= 1'b1;
                    r_main  <= in_data;
                end else if (w_send) begin
                    r_valid <= 1'b0;
                end
            end

            assign in_ready  = ~r_valid | out_ready;
            assign out_valid = r_valid;
            assign out_data  = r_main;
            assign occupancy = {1'b0, r_valid};
        end else begin : g_skid
            logic [1:0]        r_state;
            logic [1:0]        w_state_nxt;
            logic              r_in_ready;
            logic [DATA_W-1:0] r_main;
            logic [DATA_W-1:0] r_skid;
            logic              w_load_main_in;
            logic              w_load_main_skid;
            logic              w_load_skid;

            // in_ready is precomputed from the next state so it never
            // depends combinationally on out_ready.
            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    r_state    <= ST_EMPTY;
                    r_in_ready <= 1'b1;
                end else begin
                    r_state    <= w_state_nxt;
                    r_in_ready <= (w_state_nxt != ST_FULL);
                end
            end

            always_comb begin
                w_state_nxt = r_state;
                case (r_state)
                    ST_EMPTY: if (w_accept) w_state_nxt = ST_BUSY;
                    ST_BUSY: begin
                        if (w_accept && !w_send)      w_state_nxt = ST_FULL;
                        else if (!w_accept && w_send) w_state_nxt = ST_EMPTY;
                    end
                    ST_FULL:  if (w_send) w_state_nxt = ST_BUSY;
                    default:  w_state_nxt = ST_EMPTY;
                endcase
            end

            always_comb begin
                w_load_main_in   = 1'b0;
                w_load_main_skid = 1'b0;
                w_load_skid      = 1'b0;
                case (r_state)
                    ST_EMPTY: w_load_main_in   = w_accept;
                    ST_BUSY: begin
                        w_load_main_in     = w_accept & w_send;
                        w_load_skid        = w_accept & ~w_send;
                    end
                    ST_FULL:  w_load_main_skid = w_send;
                    default: ;
                endcase
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_main <= RESET_DATA;
                    r_skid <= RESET_DATA;
                end else if (flush) begin
                    if (CLEAR_ON_FLUSH != 0) begin
                        r_main <= '0;
                        r_skid <= '0;
                    end
                end else begin
                    if (w_load_main_in)        r_main <= in_data;
                    else if (w_load_main_skid) r_main <= r_skid;
                    if (w_load_skid)           r_skid <= in_data;
                end
            end

            assign in_ready  = r_in_ready;
            assign out_valid = (r_state != ST_EMPTY);
            assign out_data  = r_main;
            assign occupancy = r_state;

`ifndef SYNTHESIS
            a_full_blocks_input: assert property (@(posedge clk) disable iff (rst)
                !((r_state == ST_FULL) && r_in_ready));
`endif
        end
    endgenerate

`ifndef SYNTHESIS
    a_occupancy_range: assert property (@(posedge clk) disable iff (rst)
        occupancy != 2'd3);
    a_stall_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22041207_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22041207_pipe_stage
// Brief    : Directed bench for both pipe_stage variants against a FIFO model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_22041207_pipe_stage;

    localparam int          W  = 16;
    localparam logic [15:0] RD = 16'h5A5A;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          out_ready;

    logic          rdy0, ov0, rdy1, ov1;
    logic [W-1:0]  od0, od1;
    logic [1:0]    occ0, occ1;

    int checks   = 0;
    int failures = 0;

    ysyx_22041207_pipe_stage #(.DATA_W(W), .SKID(0), .CLEAR_ON_FLUSH(1), .RESET_DATA(RD)) u0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .occupancy(occ0));

    ysyx_22041207_pipe_stage #(.DATA_W(W), .SKID(1), .CLEAR_ON_FLUSH(1), .RESET_DATA(RD)) u1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .occupancy(occ1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model: a FIFO of held beats ----------------
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    logic [W-1:0] last0, last1;
    bit           started = 0;

    function automatic logic m_ready(input int skid, input int size, input logic ordy);
        if (skid != 0) return (size < 2);
        return (size == 0) || ordy;
    endfunction

    always @(posedge clk) begin
        bit a0, s0, a1, s1;
        if (rst) begin
            q0.delete(); q1.delete();
            last0 = RD;  last1 = RD;
        end else if (flush) begin
            q0.delete(); q1.delete();
            last0 = '0;  last1 = '0;
        end else begin
            a0 = in_valid && m_ready(0, q0.size(), out_ready);
            s0 = (q0.size() > 0) && out_ready;
            a1 = in_valid && m_ready(1, q1.size(), out_ready);
            s1 = (q1.size() > 0) && out_ready;
            if (s0) void'(q0.pop_front());
            if (a0) q0.push_back(in_data);
            if (s1) void'(q1.pop_front());
            if (a1) q1.push_back(in_data);
        end
        if (q0.size() > 0) last0 = q0[0];
        if (q1.size() > 0) last1 = q1[0];
        started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m0_out_valid", {15'd0, ov0},  {15'd0, q0.size() > 0});
            chk("m0_occupancy", {14'd0, occ0}, 16'(q0.size()));
            chk("m0_out_data",  od0,           last0);
            chk("m0_in_ready",  {15'd0, rdy0}, {15'd0, m_ready(0, q0.size(), out_ready)});
            chk("m1_out_valid", {15'd0, ov1},  {15'd0, q1.size() > 0});
            chk("m1_occupancy", {14'd0, occ1}, 16'(q1.size()));
            chk("m1_out_data",  od1,           last1);
            chk("m1_in_ready",  {15'd0, rdy1}, {15'd0, m_ready(1, q1.size(), out_ready)});
        end
    end

    // ---------------- directed stimulus with literal expectations ----------------
    task automatic set_in(input logic r, input logic f, input logic iv,
                          input logic [15:0] d, input logic ordy);
        rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic f, input logic iv,
                         input logic [15:0] d, input logic ordy);
        set_in(r, f, iv, d, ordy);
        tick();
    endtask

    initial begin
        set_in(1, 0, 1, 16'hAA, 0);
        tick();
        tick();
        chk("rst_out_valid", {15'd0, ov1}, 16'd0);
        chk("rst_occupancy", {14'd0, occ1}, 16'd0);
        chk("rst_out_data1", od1, RD);
        chk("rst_out_data0", od0, RD);
        set_in(0, 0, 0, 16'h0, 0);
        #1;
        chk("rst_in_ready", {15'd0, rdy1}, 16'd1);

        // streaming, one beat per cycle, latency 1
        for (int i = 1; i <= 8; i++) begin
            drive(0, 0, 1, 16'(i), 1);
            chk("stream_data1", od1, 16'(i));
            chk("stream_valid1", {15'd0, ov1}, 16'd1);
            chk("stream_ready1", {15'd0, rdy1}, 16'd1);
            chk("stream_data0", od0, 16'(i));
        end
        drive(0, 0, 0, 16'h0, 1);
        chk("drain_occ1", {14'd0, occ1}, 16'd0);
        chk("drain_data1", od1, 16'h8);

        // back-pressure into the skid register
        drive(0, 0, 1, 16'h10, 0);
        chk("bp_occ_a", {14'd0, occ1}, 16'd1);
        drive(0, 0, 1, 16'h11, 0);
        chk("bp_occ_b", {14'd0, occ1}, 16'd2);
        chk("bp_ready_b", {15'd0, rdy1}, 16'd0);
        drive(0, 0, 1, 16'h12, 0);
        chk("bp_occ_c", {14'd0, occ1}, 16'd2);
        chk("bp_hold1", od1, 16'h10);
        chk("bp_hold0", od0, 16'h10);
        drive(0, 0, 1, 16'h12, 1);
        chk("bp_out_11", od1, 16'h11);
        chk("bp_occ_d", {14'd0, occ1}, 16'd1);
        drive(0, 0, 1, 16'h12, 1);
        chk("bp_out_12", od1, 16'h12);
        drive(0, 0, 0, 16'h0, 1);
        chk("bp_empty", {15'd0, ov1}, 16'd0);

        // flush while FULL, colliding with send and accept
        drive(0, 0, 1, 16'h20, 0);
        drive(0, 0, 1, 16'h21, 0);
        chk("fl_occ_full", {14'd0, occ1}, 16'd2);
        chk("fl_main", od1, 16'h20);
        drive(0, 1, 1, 16'h22, 1);
        chk("fl_occ", {14'd0, occ1}, 16'd0);
        chk("fl_valid1", {15'd0, ov1}, 16'd0);
        chk("fl_data1", od1, 16'h0);
        chk("fl_valid0", {15'd0, ov0}, 16'd0);
        chk("fl_data0", od0, 16'h0);

        // SKID=0 stall and same-cycle release
        drive(0, 0, 1, 16'h30, 0);
        chk("st_data0", od0, 16'h30);
        set_in(0, 0, 1, 16'h31, 0);
        #1;
        chk("st_ready_lo", {15'd0, rdy0}, 16'd0);
        tick();
        chk("st_hold", od0, 16'h30);
        set_in(0, 0, 1, 16'h31, 1);
        #1;
        chk("st_ready_hi", {15'd0, rdy0}, 16'd1);
        tick();
        chk("st_next", od0, 16'h31);
        chk("st_valid", {15'd0, ov0}, 16'd1);

        // reset while FULL
        drive(0, 0, 1, 16'h40, 0);
        chk("rm_occ_full", {14'd0, occ1}, 16'd2);
        drive(1, 0, 1, 16'h41, 1);
        chk("rm_occ", {14'd0, occ1}, 16'd0);
        chk("rm_valid", {15'd0, ov1}, 16'd0);
        chk("rm_data1", od1, RD);
        chk("rm_data0", od0, RD);
        drive(0, 0, 0, 16'h0, 1);
        drive(0, 0, 0, 16'h0, 1);
        chk("rm_no_stale1", {15'd0, ov1}, 16'd0);
        chk("rm_no_stale0", {15'd0, ov0}, 16'd0);
        chk("rm_keep_data1", od1, RD);

        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
